// File: rtl/mem_lsu_stage.sv
// rtl/mem_lsu_stage.sv - MEM/LSU pipeline stage between EX and WB with SRAM req/gnt/rvalid port
// Optional: define MEM_ALIGN_CHECK_EN to trap misaligned accesses instead of truncating them.
module mem_lsu_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [3:0]        ex_mem_op,
  input  logic              ex_rf_we,
  input  logic [REG_AW-1:0] ex_rf_waddr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              data_sram_req,
  output logic              data_sram_we,
  output logic [STRB_W-1:0] data_sram_wstrb,
  output logic [DATA_W-1:0] data_sram_addr,
  output logic [DATA_W-1:0] data_sram_wdata,
  input  logic              data_sram_gnt,
  input  logic              data_sram_rvalid,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_rf_we,
  output logic [REG_AW-1:0] wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              wb_exc,
  output logic              fwd_we,
  output logic [REG_AW-1:0] fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_pending
);
  localparam int OFF_W = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;
  state_t state_q, state_d;

  // Returns {load, store, unsigned, size}; size 0..3 = byte/half/word/dword.
  function automatic logic [4:0] decode(input logic [3:0] op);
    logic [4:0] d;
    d = 5'b0;
    case (op)
      4'b1000: d = 5'b10000;
      4'b1001: d = 5'b10001;
      4'b1010: d = 5'b10010;
      4'b1011: d = (DATA_W == 64) ? 5'b10011 : 5'b0;
      4'b1100: d = 5'b10100;
      4'b1101: d = 5'b10101;
      4'b1110: d = (DATA_W == 64) ? 5'b10110 : 5'b0;
      4'b0001: d = 5'b01000;
      4'b0010: d = 5'b01001;
      4'b0011: d = 5'b01010;
      4'b0100: d = (DATA_W == 64) ? 5'b01011 : 5'b0;
      default: d = 5'b0;
    endcase
    return d;
  endfunction

  logic              ex_ld, ex_st, ex_uns, ex_bad, accept;
  logic [1:0]        ex_size;
  logic              ld_q, st_q, uns_q, rf_we_q, exc;
  logic [1:0]        size_q;
  logic [PC_W-1:0]   pc_q;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] addr_q, sdata_q, wdata_q;

  assign {ex_ld, ex_st, ex_uns, ex_size} = decode(ex_mem_op);
  assign accept = ex_valid & ex_ready;

`ifdef MEM_ALIGN_CHECK_EN
  logic exc_q;
  assign ex_bad = (ex_ld | ex_st) &
                  (((ex_size == 2'd1) & ex_result[0]) |
                   ((ex_size == 2'd2) & (|ex_result[1:0])) |
                   ((ex_size == 2'd3) & (|ex_result[2:0])));
  assign exc = exc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         exc_q <= 1'b0;
    else if (accept) exc_q <= ex_bad;
  end
`else
  assign ex_bad = 1'b0;
  assign exc    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    ex_ready      = 1'b0;
    data_sram_req = 1'b0;
    wb_valid      = 1'b0;
    case (state_q)
      IDLE: ex_ready = !rst;
      REQ: begin
        data_sram_req = 1'b1;
        if (data_sram_gnt) state_d = st_q ? OUT : RESP;
      end
      RESP: if (data_sram_rvalid) state_d = OUT;
      OUT: begin
        wb_valid = 1'b1;
        ex_ready = !rst & wb_ready;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) state_d = ((ex_ld | ex_st) & !ex_bad) ? REQ : OUT;
  end

  // Lane offset with the low bits below the access size dropped.
  logic [OFF_W-1:0]         off;
  logic [6:0]               lsh;
  logic [DATA_W-1:0]        rsh, rtmp, ld_data;
  logic signed [DATA_W-1:0] sext;

  always_comb begin
    off     = addr_q[OFF_W-1:0] & ~OFF_W'((32'd1 << size_q) - 32'd1);
    lsh     = 7'(DATA_W) - (7'd8 << size_q);
    rsh     = data_sram_rdata >> {off, 3'b000};
    rtmp    = rsh << lsh;
    sext    = $signed(rtmp) >>> lsh;
    ld_data = uns_q ? (rtmp >> lsh) : sext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      rf_we_q <= 1'b0;
      pc_q    <= '0;
      waddr_q <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      ld_q    <= ex_ld;
      st_q    <= ex_st;
      uns_q   <= ex_uns;
      size_q  <= ex_size;
      rf_we_q <= ex_rf_we;
      pc_q    <= ex_pc;
      waddr_q <= ex_rf_waddr;
      addr_q  <= ex_result;
      sdata_q <= ex_store_data;
      wdata_q <= ex_result;
    end else if (state_q == RESP && data_sram_rvalid) begin
      wdata_q <= ld_data;
    end
  end

  assign data_sram_we    = data_sram_req & st_q;
  assign data_sram_wstrb = data_sram_we ?
                           (STRB_W'((32'd1 << (32'd1 << size_q)) - 32'd1) << off) : '0;
  assign data_sram_addr  = {addr_q[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
  assign data_sram_wdata = sdata_q << {off, 3'b000};

  assign wb_pc       = pc_q;
  assign wb_rf_we    = rf_we_q & !st_q & (waddr_q != '0) & !exc;
  assign wb_rf_waddr = waddr_q;
  assign wb_rf_wdata = wdata_q;
  assign wb_exc      = exc;

  // Loads only forward once their data has landed in OUT.
  assign fwd_we      = (state_q != IDLE) & wb_rf_we & (!ld_q | (state_q == OUT));
  assign fwd_waddr   = waddr_q;
  assign fwd_wdata   = wdata_q;
  assign fwd_pending = ld_q & rf_we_q & ((state_q == REQ) | (state_q == RESP));
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb/tb_mem_lsu_stage.sv - directed self-checking bench for mem_lsu_stage
module tb_mem_lsu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_rf_we;
  logic [31:0] ex_pc, ex_result, ex_store_data;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rf_waddr;
  logic        data_sram_req, data_sram_we, data_sram_gnt, data_sram_rvalid;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        wb_valid, wb_ready, wb_rf_we, wb_exc, fwd_we, fwd_pending;
  logic [31:0] wb_pc, wb_rf_wdata, fwd_wdata;
  logic [4:0]  wb_rf_waddr, fwd_waddr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_lsu_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_mem_op(ex_mem_op),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .ex_store_data(ex_store_data),
    .data_sram_req(data_sram_req), .data_sram_we(data_sram_we),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_gnt(data_sram_gnt),
    .data_sram_rvalid(data_sram_rvalid), .data_sram_rdata(data_sram_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata), .wb_exc(wb_exc),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_pending(fwd_pending)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic we, input logic [4:0] wa);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_result     = res;
    ex_store_data = sd;
    ex_rf_we      = we;
    ex_rf_waddr   = wa;
    ex_pc         = 32'h1000 + res;
  endtask

  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp);
    drive(op, addr, 32'h0, 1'b1, 5'd6);
    data_sram_gnt = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check({tag, "_req"}, {63'd0, data_sram_req}, 64'd1);
    check({tag, "_addr"}, {32'd0, data_sram_addr}, {32'd0, addr & 32'hFFFF_FFFC});
    @(negedge clk);
    data_sram_gnt    = 1'b0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata  = rdata;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    #1 check({tag, "_valid"}, {63'd0, wb_valid}, 64'd1);
    check({tag, "_data"}, {32'd0, wb_rf_wdata}, {32'd0, exp});
    @(negedge clk);
  endtask

  task automatic do_store(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [3:0] strb, input logic [31:0] wd);
    drive(op, addr, sd, 1'b1, 5'd9);
    data_sram_gnt = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check({tag, "_we"}, {63'd0, data_sram_we}, 64'd1);
    check({tag, "_strb"}, {60'd0, data_sram_wstrb}, {60'd0, strb});
    check({tag, "_wdata"}, {32'd0, data_sram_wdata}, {32'd0, wd});
    check({tag, "_addr"}, {32'd0, data_sram_addr}, {32'd0, addr & 32'hFFFF_FFFC});
    @(negedge clk);
    data_sram_gnt = 1'b0;
    #1 check({tag, "_wbvalid"}, {63'd0, wb_valid}, 64'd1);
    check({tag, "_rfwe"}, {63'd0, wb_rf_we}, 64'd0);
    check({tag, "_fwdwe"}, {63'd0, fwd_we}, 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_op = 4'd0; ex_rf_we = 1'b0; ex_rf_waddr = 5'd0;
    ex_pc = 32'd0; ex_result = 32'd0; ex_store_data = 32'd0;
    data_sram_gnt = 1'b0; data_sram_rvalid = 1'b0; data_sram_rdata = 32'd0;
    wb_ready = 1'b1;
    #1 check("rst_ex_ready", {63'd0, ex_ready}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("reset_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("reset_req", {63'd0, data_sram_req}, 64'd0);
    check("reset_rf_we", {63'd0, wb_rf_we}, 64'd0);
    check("reset_pending", {63'd0, fwd_pending}, 64'd0);
    check("reset_ex_ready", {63'd0, ex_ready}, 64'd1);

    // ALU op: one-cycle latency and forwarding while held
    drive(4'b0000, 32'h1234, 32'h0, 1'b1, 5'd3);
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check("alu_valid", {63'd0, wb_valid}, 64'd1);
    check("alu_data", {32'd0, wb_rf_wdata}, 64'h1234);
    check("alu_rf_we", {63'd0, wb_rf_we}, 64'd1);
    check("alu_fwd_we", {63'd0, fwd_we}, 64'd1);
    check("alu_fwd_addr", {59'd0, fwd_waddr}, 64'd3);
    check("alu_pc", {32'd0, wb_pc}, 64'h2234);
    @(negedge clk);
    #1 check("alu_done", {63'd0, wb_valid}, 64'd0);

    // LB with two wait states; rvalid during the gnt cycle must be ignored
    drive(4'b1000, 32'h103, 32'h0, 1'b1, 5'd5);
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check("lb_req", {63'd0, data_sram_req}, 64'd1);
    check("lb_addr", {32'd0, data_sram_addr}, 64'h100);
    check("lb_pending", {63'd0, fwd_pending}, 64'd1);
    check("lb_fwd_we", {63'd0, fwd_we}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1 check("lb_wait_req", {63'd0, data_sram_req}, 64'd1);
    data_sram_gnt = 1'b1; data_sram_rvalid = 1'b1; data_sram_rdata = 32'h0000_0000;
    @(negedge clk);
    data_sram_gnt = 1'b0; data_sram_rvalid = 1'b0;
    #1 check("lb_resp_req", {63'd0, data_sram_req}, 64'd0);
    check("lb_resp_valid", {63'd0, wb_valid}, 64'd0);
    check("lb_resp_pending", {63'd0, fwd_pending}, 64'd1);
    data_sram_rvalid = 1'b1; data_sram_rdata = 32'h8012_3456;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    #1 check("lb_valid", {63'd0, wb_valid}, 64'd1);
    check("lb_data", {32'd0, wb_rf_wdata}, 64'hFFFF_FF80);
    check("lb_out_pending", {63'd0, fwd_pending}, 64'd0);
    check("lb_out_fwd_we", {63'd0, fwd_we}, 64'd1);
    @(negedge clk);

    do_load("lhu", 4'b1101, 32'h102, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("lh",  4'b1001, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lbu", 4'b1100, 32'h101, 32'h0000_F000, 32'h0000_00F0);
    do_load("lw",  4'b1010, 32'h204, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    do_store("sb", 4'b0001, 32'h101, 32'h0000_00AB, 4'b0010, 32'h0000_AB00);
    do_store("sh", 4'b0010, 32'h102, 32'h0000_BEEF, 4'b1100, 32'hBEEF_0000);
    do_store("sw", 4'b0011, 32'h104, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    // LD is not legal at 32 bits: behaves as a non-memory op
    drive(4'b1011, 32'h77, 32'h0, 1'b1, 5'd4);
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check("ld32_req", {63'd0, data_sram_req}, 64'd0);
    check("ld32_valid", {63'd0, wb_valid}, 64'd1);
    check("ld32_data", {32'd0, wb_rf_wdata}, 64'h77);
    @(negedge clk);

    // waddr 0 suppresses both write enables
    drive(4'b0000, 32'h99, 32'h0, 1'b1, 5'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check("x0_rf_we", {63'd0, wb_rf_we}, 64'd0);
    check("x0_fwd_we", {63'd0, fwd_we}, 64'd0);
    @(negedge clk);

    // back-to-back LW then ALU with WB stalled for three cycles
    wb_ready = 1'b0;
    drive(4'b1010, 32'h200, 32'h0, 1'b1, 5'd7);
    data_sram_gnt = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    data_sram_gnt = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    drive(4'b0000, 32'h55, 32'h0, 1'b1, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_valid", {63'd0, wb_valid}, 64'd1);
      check("stall_data", {32'd0, wb_rf_wdata}, 64'hCAFE_F00D);
      check("stall_ex_ready", {63'd0, ex_ready}, 64'd0);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    #1 check("b2b_ex_ready", {63'd0, ex_ready}, 64'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    #1 check("b2b_valid", {63'd0, wb_valid}, 64'd1);
    check("b2b_data", {32'd0, wb_rf_wdata}, 64'h55);
    check("b2b_waddr", {59'd0, wb_rf_waddr}, 64'd8);
    @(negedge clk);
    #1 check("b2b_idle", {63'd0, wb_valid}, 64'd0);

    // reset while waiting for read data, then a stray rvalid
    drive(4'b1010, 32'h300, 32'h0, 1'b1, 5'd10);
    data_sram_gnt = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    data_sram_gnt = 1'b0;
    rst = 1'b1;
    #1 check("rstmid_ex_ready", {63'd0, ex_ready}, 64'd0);
    check("rstmid_pending", {63'd0, fwd_pending}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    data_sram_rvalid = 1'b1; data_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    #1 check("rstmid_valid", {63'd0, wb_valid}, 64'd0);
    check("rstmid_req", {63'd0, data_sram_req}, 64'd0);
    check("rstmid_ex_ready", {63'd0, ex_ready}, 64'd1);

    // misaligned LW
    drive(4'b1010, 32'h102, 32'h0, 1'b1, 5'd11);
    @(negedge clk);
    ex_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    #1 check("mis_req", {63'd0, data_sram_req}, 64'd0);
    check("mis_valid", {63'd0, wb_valid}, 64'd1);
    check("mis_exc", {63'd0, wb_exc}, 64'd1);
    check("mis_rf_we", {63'd0, wb_rf_we}, 64'd0);
    check("mis_fwd_we", {63'd0, fwd_we}, 64'd0);
    @(negedge clk);
`else
    #1 check("mis_req", {63'd0, data_sram_req}, 64'd1);
    check("mis_addr", {32'd0, data_sram_addr}, 64'h100);
    data_sram_gnt = 1'b1;
    @(negedge clk);
    data_sram_gnt = 1'b0; data_sram_rvalid = 1'b1; data_sram_rdata = 32'h1122_3344;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    #1 check("mis_exc", {63'd0, wb_exc}, 64'd0);
    check("mis_data", {32'd0, wb_rf_wdata}, 64'h1122_3344);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Parametrised successor of the MEM pipeline stage, placed between EX and WB.
- Holds one instruction at a time with valid/ready handshakes on both sides.
- Drives a data SRAM port with req/gnt/rvalid, so the SRAM may insert wait states.
- Performs byte/half/word(/dword) load alignment with sign or zero extension, and store strobe/lane generation.
- Provides forwarding and load-use stall information to ID.

Parameters:
- DATA_W, 32, data/register width; legal values 32 or 64.
- PC_W, 32, width of carried PC.
- REG_AW, 5, register-file address width.
- STRB_W, DATA_W/8, derived byte-strobe width. Never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage accepts this cycle
- ex_pc  in  PC_W  instruction PC
- ex_mem_op  in  4  memory op encoding (below)
- ex_rf_we  in  1  writes register file
- ex_rf_waddr  in  REG_AW  destination register
- ex_result  in  DATA_W  ALU result; effective address for memory ops
- ex_store_data  in  DATA_W  unaligned store data (low bytes)
- data_sram_req  out  1  request valid
- data_sram_we  out  1  1 = write
- data_sram_wstrb  out  STRB_W  byte enables
- data_sram_addr  out  DATA_W  address, aligned down to STRB_W
- data_sram_wdata  out  DATA_W  lane-shifted store data
- data_sram_gnt  in  1  request accepted
- data_sram_rvalid  in  1  read data valid
- data_sram_rdata  in  DATA_W  read data
- wb_valid  out  1  result valid to WB
- wb_ready  in  1  WB accepts
- wb_pc  out  PC_W
- wb_rf_we  out  1
- wb_rf_waddr  out  REG_AW
- wb_rf_wdata  out  DATA_W
- wb_exc  out  1  misaligned-access flag
- fwd_we  out  1  forwarding data valid
- fwd_waddr  out  REG_AW
- fwd_wdata  out  DATA_W
- fwd_pending  out  1  load in flight targets fwd_waddr; ID must stall on match

Behaviour:
- mem_op encoding:
  - 0000 none
  - 1000 LB, 1001 LH, 1010 LW, 1011 LD
  - 1100 LBU, 1101 LHU, 1110 LWU
  - 0001 SB, 0010 SH, 0011 SW, 0100 SD
  - LD, LWU and SD are legal only when DATA_W=64; otherwise they are treated as none.
- FSM states: IDLE, REQ, RESP, OUT. Reset (async) forces IDLE; all registered outputs are 0.
- ex_ready is 0 while rst is high. Otherwise ex_ready = (IDLE) | (OUT & wb_ready).
- Accept (ex_valid & ex_ready) latches all ex_* fields. Next state: REQ for a memory op, OUT otherwise.
- REQ:
  - data_sram_req=1; addr/we/wstrb/wdata are stable until gnt.
  - On gnt: store goes to OUT; load goes to RESP.
- RESP:
  - Waits for rvalid; any rvalid in the gnt cycle is ignored.
  - On rvalid: select lanes by addr low bits, extend per op, store into wdata, go to OUT.
- OUT:
  - wb_valid=1 and outputs are held until wb_ready.
  - wb_ready & ex_valid: accept the next instruction the same cycle (back-to-back).
  - wb_ready & !ex_valid: go to IDLE.
- Latency:
  - Non-memory op accepted at cycle N: wb_valid at N+1.
  - Load with gnt at N+1 and rvalid at N+2: wb_valid at N+3.
  - Store with gnt at N+1: wb_valid at N+2.
- Write-enable gating:
  - Stores force wb_rf_we=0.
  - waddr==0 forces wb_rf_we=0 and fwd_we=0.
- Forwarding:
  - fwd_we=1 for a held entry with rf_we when it is non-load in any state, or a load in OUT.
  - fwd_pending=1 for a load with rf_we in REQ or RESP.
  - fwd_waddr/fwd_wdata mirror the held entry.
- Reset mid-transaction abandons the access. A late rvalid in IDLE/REQ/OUT is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: a misaligned half/word/dword address issues no SRAM request; the FSM goes straight to OUT with wb_exc=1, wb_rf_we=0, fwd_we=0.
- Undefined: wb_exc is tied 0; the offending low address bits are cleared to the access size and the access proceeds.

Test Plan:
- ALU op, ex_result=0x1234, waddr=3, wb_ready=1 -> wb_valid next cycle; wb_rf_wdata=0x1234; fwd_we=1 during the hold cycle.
- LB at addr 0x103, rdata=0x80xxxxxx, gnt after 2 wait cycles -> wb_rf_wdata=0xFFFFFF80; fwd_pending=1 until OUT.
- LHU at 0x102, rdata=0xBEEF0000 -> 0x0000BEEF.
- SB at 0x101, data 0xAB -> wstrb=0010, wdata=0x0000AB00, we=1, wb_rf_we=0.
- Back-to-back LW then ALU op with wb_ready held 0 for 3 cycles -> outputs stable; ex_ready=0; second op accepted the cycle wb_ready rises.
- rst asserted in RESP, then rvalid pulse -> state IDLE; no wb_valid.
- With MEM_ALIGN_CHECK_EN: LW at 0x102 -> no req; wb_exc=1.
